// File: rtl/sram_share_arbiter.sv
// Shares one single-port SRAM between inst-fetch and data ports; data has priority, a streak limiter forces an inst grant.
// Grant is combinational with req; data_ok follows addr_ok by exactly one cycle; no response backpressure.
module sram_share_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic {
    DATA_PRI = 1'b0,
    INST_PRI = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] STREAK_LAST = CNT_W'(STREAK_MAX - 1);
  localparam logic [CNT_W-1:0] STREAK_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_owner_q, resp_owner_d;

  logic             inst_gnt, data_gnt, any_gnt, contend;
  logic [3:0]       wen_sel;

  assign contend = inst_req & data_req;

  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (state_q == DATA_PRI) begin
      data_gnt = data_req;
      inst_gnt = inst_req & ~data_req;
    end else begin
      inst_gnt = inst_req;
      data_gnt = data_req & ~inst_req;
    end
  end

  assign any_gnt = inst_gnt | data_gnt;

  always_comb begin
    wen_sel = 4'b0000;
    if (data_gnt) begin
      wen_sel = data_wr ? data_wstrb : 4'b0000;
    end else if (inst_gnt) begin
      wen_sel = inst_wr ? inst_wstrb : 4'b0000;
    end
  end

  // Handshake outputs are held low while reset is asserted, even with requests pending.
  assign inst_addr_ok = inst_gnt & resetn;
  assign data_addr_ok = data_gnt & resetn;
  assign sram_en      = any_gnt & resetn;
  assign sram_wen     = resetn ? wen_sel : 4'b0000;
  assign sram_addr    = data_gnt ? data_addr  : inst_addr;
  assign sram_wdata   = data_gnt ? data_wdata : inst_wdata;

  assign inst_data_ok = resp_valid_q & ~resp_owner_q;
  assign data_data_ok = resp_valid_q & resp_owner_q;
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    resp_valid_d = any_gnt;
    resp_owner_d = data_gnt;
    case (state_q)
      DATA_PRI: begin
        if (contend) begin
          if (streak_q == STREAK_LAST) begin
            state_d  = INST_PRI;
            streak_d = '0;
          end else begin
            streak_d = streak_q + STREAK_ONE;
          end
        end else begin
          streak_d = '0;
        end
      end
      // One-shot: inst priority lasts exactly one cycle whatever happens in it.
      INST_PRI: begin
        state_d  = DATA_PRI;
        streak_d = '0;
      end
      default: begin
        state_d  = DATA_PRI;
        streak_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= DATA_PRI;
      streak_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

endmodule

// File: tb/tb_sram_share_arbiter.sv
// Directed vector bench for sram_share_arbiter with a behavioural 1-cycle-latency SRAM behind it.
module tb_sram_share_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int checks;
  int errors;

  always #5 clk = ~clk;

  sram_share_arbiter #(.STREAK_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Word i of the memory holds 0x10000000 + i after reset.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + k;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr[9:2]];
    end
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [3:0]  dstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [6:0]  exp_gnt;   // {inst_addr_ok, data_addr_ok, sram_en, sram_wen}
    logic [1:0]  exp_ok;    // {inst_data_ok, data_data_ok}
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
  } vec_t;

  localparam logic [6:0] IG = 7'b101_0000;
  localparam logic [6:0] DG = 7'b011_0000;
  localparam logic [6:0] DW = 7'b011_0011;
  localparam logic [6:0] NG = 7'b000_0000;
  localparam logic [31:0] IA = 32'hBFC0_0010;
  localparam logic [31:0] DA = 32'h0000_0104;
  localparam logic [31:0] RI = 32'h1000_0004;
  localparam logic [31:0] RD = 32'h1000_0041;

  vec_t vt [34];

  function automatic vec_t mk(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                              input logic dwr, input logic [3:0] dstrb, input logic [31:0] daddr,
                              input logic [31:0] dwdata, input logic [6:0] eg, input logic [1:0] eo,
                              input logic crd, input logic [31:0] erd, input logic [31:0] ea);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwr = dwr; v.dstrb = dstrb;
    v.daddr = daddr; v.dwdata = dwdata; v.exp_gnt = eg; v.exp_ok = eo;
    v.chk_rd = crd; v.exp_rd = erd; v.exp_addr = ea;
    return v;
  endfunction

  function automatic vec_t con(input logic [6:0] eg, input logic [1:0] eo, input logic crd,
                               input logic [31:0] erd);
    return mk(1, IA, 1, 0, 4'hF, DA, 0, eg, eo, crd, erd, (eg == IG) ? IA : DA);
  endfunction

  function automatic vec_t idle(input logic [1:0] eo, input logic [31:0] erd);
    return mk(0, IA, 0, 0, 4'hF, DA, 0, NG, eo, 1, erd, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    inst_req   = v.ireq;
    inst_addr  = v.iaddr;
    data_req   = v.dreq;
    data_wr    = v.dwr;
    data_wstrb = v.dstrb;
    data_addr  = v.daddr;
    data_wdata = v.dwdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    inst_wr    = 1'b0;
    inst_wstrb = 4'hF;
    inst_wdata = 32'hDEAD_BEEF;

    // Inst-only read stream, then data write/read on 0x100.
    vt[0]  = mk(1, 32'hBFC0_0000, 0, 0, 4'hF, 0, 0, IG, 2'b00, 0, 0, 32'hBFC0_0000);
    vt[1]  = mk(1, 32'hBFC0_0004, 0, 0, 4'hF, 0, 0, IG, 2'b10, 1, 32'h1000_0000, 32'hBFC0_0004);
    vt[2]  = mk(1, 32'hBFC0_0008, 0, 0, 4'hF, 0, 0, IG, 2'b10, 1, 32'h1000_0001, 32'hBFC0_0008);
    vt[3]  = idle(2'b10, 32'h1000_0002);
    vt[4]  = mk(0, IA, 1, 1, 4'b0011, 32'h100, 32'hAAAA_5555, DW, 2'b00, 0, 0, 32'h100);
    vt[5]  = mk(0, IA, 1, 0, 4'hF, 32'h100, 0, DG, 2'b01, 0, 0, 32'h100);
    vt[6]  = idle(2'b01, 32'h1000_5555);
    // Continuous contention: D,D,D,D,I twice.
    vt[7]  = con(DG, 2'b00, 0, 0);
    vt[8]  = con(DG, 2'b01, 1, RD);
    vt[9]  = con(DG, 2'b01, 1, RD);
    vt[10] = con(DG, 2'b01, 1, RD);
    vt[11] = con(IG, 2'b01, 1, RD);
    vt[12] = con(DG, 2'b10, 1, RI);
    vt[13] = con(DG, 2'b01, 1, RD);
    vt[14] = con(DG, 2'b01, 1, RD);
    vt[15] = con(DG, 2'b01, 1, RD);
    vt[16] = con(IG, 2'b01, 1, RD);
    vt[17] = idle(2'b10, RI);
    // Streak broken by an uncontended inst grant.
    vt[18] = con(DG, 2'b00, 0, 0);
    vt[19] = con(DG, 2'b01, 1, RD);
    vt[20] = mk(1, IA, 0, 0, 4'hF, DA, 0, IG, 2'b01, 1, RD, IA);
    vt[21] = con(DG, 2'b10, 1, RI);
    vt[22] = con(DG, 2'b01, 1, RD);
    vt[23] = con(DG, 2'b01, 1, RD);
    vt[24] = con(DG, 2'b01, 1, RD);
    vt[25] = con(IG, 2'b01, 1, RD);
    vt[26] = idle(2'b10, RI);
    // Inst priority cycle consumed by a data-only request.
    vt[27] = con(DG, 2'b00, 0, 0);
    vt[28] = con(DG, 2'b01, 1, RD);
    vt[29] = con(DG, 2'b01, 1, RD);
    vt[30] = con(DG, 2'b01, 1, RD);
    vt[31] = mk(0, IA, 1, 0, 4'hF, DA, 0, DG, 2'b01, 1, RD, DA);
    vt[32] = con(DG, 2'b01, 1, RD);
    vt[33] = idle(2'b01, RD);

    // Reset with both ports requesting a write.
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = IA;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = DA; data_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("rst inst_addr_ok", inst_addr_ok, 0);
    chk("rst data_addr_ok", data_addr_ok, 0);
    chk("rst sram_en", sram_en, 0);
    chk("rst sram_wen", sram_wen, 0);
    chk("rst data_ok", {inst_data_ok, data_data_ok}, 0);
    data_wr = 1'b0;
    resetn  = 1'b1;
    #1;
    chk("first grant", {inst_addr_ok, data_addr_ok}, 2'b01);
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("first resp ok", {inst_data_ok, data_data_ok}, 2'b01);
    chk("first resp rdata", data_rdata, RD);

    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #1;
      drive(vt[i]);
      @(negedge clk);
      chk($sformatf("v%0d grant", i), {inst_addr_ok, data_addr_ok, sram_en, sram_wen}, vt[i].exp_gnt);
      chk($sformatf("v%0d data_ok", i), {inst_data_ok, data_data_ok}, vt[i].exp_ok);
      if (vt[i].exp_gnt[4]) chk($sformatf("v%0d sram_addr", i), sram_addr, vt[i].exp_addr);
      if (vt[i].exp_gnt[3:0] != 4'b0) chk($sformatf("v%0d sram_wdata", i), sram_wdata, vt[i].dwdata);
      if (vt[i].chk_rd) begin
        if (vt[i].exp_ok[1]) chk($sformatf("v%0d inst_rdata", i), inst_rdata, vt[i].exp_rd);
        else chk($sformatf("v%0d data_rdata", i), data_rdata, vt[i].exp_rd);
      end
    end

    // Reset right after a data grant with streak at 3: response dropped, streak cleared.
    @(posedge clk); #1;
    drive(con(DG, 2'b00, 0, 0));
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("midrst data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("midrst addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    @(posedge clk); #3;
    resetn = 1'b1;
    @(negedge clk);
    chk("post-rst data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("post-rst grant 0", {inst_addr_ok, data_addr_ok}, 2'b01);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("post-rst grant %0d", k), {inst_addr_ok, data_addr_ok}, (k < 4) ? 2'b01 : 2'b10);
    end
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
